seq_det_scheduler: RTL and testbench
====================================

// Module: seq_det_scheduler
// PURPOSE
//  Time-shares one external 4-in-a-row serial run detector (inputs w, reset; output z) among N_REQ requesters.
//  Round-robin arbiter grants one requester and captures its parallel word.
//  Clears the detector, then shifts the word into it LSB first, one bit per clk.
//  Counts cycles where z=1 over the word's sample window and reports count and requester id.
// PARAMETERS
//  N_REQ   4   number of requesters, 2..8
//  WORD_W  16  bits per word, >=4
//  CNT_W   $clog2(WORD_W+1)  derived localparam, hit_count width
// PORTS
//  clk        in   1              clock, all logic on posedge
//  reset      in   1              reset, asynchronous, active-high
//  req        in   N_REQ          per-requester request level
//  req_data   in   N_REQ*WORD_W   word of requester k at [k*WORD_W +: WORD_W]
//  gnt        out  N_REQ          one-hot, 1-cycle pulse: word accepted this cycle
//  busy       out  1              high from cycle after gnt through DONE
//  done       out  1              1-cycle pulse: result valid
//  done_id    out  $clog2(N_REQ)  index of requester whose word finished
//  hit_count  out  CNT_W          number of sampled cycles with det_z=1
//  hit        out  1              hit_count != 0
//  det_clr    out  1              drives detector reset, registered, glitch-free
//  det_w      out  1              drives detector w, registered
//  det_z      in   1              detector z
// BEHAVIOUR
//  Reset values:
//   - gnt=0, busy=0, done=0, done_id=0, hit_count=0, hit=0, det_w=0, det_clr=1
//   - state=IDLE, last-grant pointer=N_REQ-1
//  IDLE: det_clr=1.
//   - If any req, pulse gnt for the first requesting index in order last+1, last+2, ... (mod N_REQ).
//   - Same cycle: capture that word into the shift register, record the id, update the pointer; next state CLEAR.
//  CLEAR: 1 cycle, det_clr=1, busy=1, accumulator zeroed.
//  SHIFT: WORD_W cycles, det_clr=0, det_w = word bit j in SHIFT cycle j (bit 0 first).
//  DRAIN: 2 cycles, det_clr=0, det_w=0.
//  DONE: 1 cycle.
//   - done=1; det_clr=1.
//   - hit_count/hit/done_id updated and held until the next DONE.
//   - Next state IDLE.
//  Sampling: detector z lags its input by 2 cycles.
//   - Sample det_z only in SHIFT cycles 2..WORD_W-1 and both DRAIN cycles (exactly WORD_W samples).
//   - Each sample with det_z=1 increments the accumulator; the accumulator saturates at WORD_W.
//  Expected count:
//   - One per position i>=3 where bits i-3..i are equal.
//   - Plus one if bits 0,1,2 are all 1: the detector's cleared history is 0101, so this case is a real hit.
//  Latency: gnt to done = WORD_W+4 cycles; min spacing between grants = WORD_W+5.
//  Arbitration rules:
//   - req seen while busy or in DONE is not granted, only held.
//   - No gnt in the DONE cycle.
//   - A requester must hold req and req_data valid until its gnt; req_data is ignored after gnt.
//   - A req dropped before its gnt is lost silently.
//  Reset mid-operation aborts the word: no done, outputs and pointer return to reset values.
//  Unused state encodings go to IDLE with det_clr=1.
// TESTING
//  1 Assert reset -> all outputs at reset values, det_clr=1; release with no req -> stays IDLE.
//  2 req=0001, word 16'h0000 -> gnt=0001 once; done 20 cycles later; hit_count=13, hit=1, done_id=0.
//  3 req=0010, word 16'hFFFF -> hit_count=14 (includes bits0..2 case), done_id=1.
//  4 Word 16'hAAAA -> hit_count=0, hit=0; word 16'h00F0 -> hit_count=7.
//  5 req=1111 held -> grants 0,1,2,3,0 in order, gnt pulses 21 cycles apart, never two bits set.
//  6 reset in SHIFT cycle 5 -> no done, det_clr=1 at once; after release req=1111 -> gnt=0001.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// Purpose : time-shares one external 4-in-a-row serial run detector among N_REQ
//           requesters; a round-robin arbiter picks a word, clears the detector,
//           streams the word LSB first and counts the cycles where det_z is high.
// Latency : gnt to done = WORD_W+4 cycles; back-to-back grants are WORD_W+5 apart.
// Backpressure: requests are only granted in IDLE; a requester holds req/req_data
//           until its gnt pulse, and a req dropped before its gnt is simply lost.
//
// Ports
//   clk, reset          clock (posedge) and asynchronous active-high reset
//   req, req_data       per-requester request level and word (k at [k*WORD_W +: WORD_W])
//   gnt                 one-hot pulse, word captured this cycle
//   busy                high from the cycle after gnt through the DONE cycle
//   done, done_id       result-valid pulse and requester index of that result
//   hit_count, hit      number of sampled cycles with det_z=1, and hit_count != 0
//   det_clr, det_w      registered reset and serial data to the detector
//   det_z               detector output, lagging det_w by two cycles
module seq_det_scheduler #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 16,
  localparam int CNT_W = $clog2(WORD_W + 1),
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          hit_count,
  output logic                      hit,
  output logic                      det_clr,
  output logic                      det_w,
  input  logic                      det_z
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ID_W-1:0]     last_ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     cur_id;
  logic                gnt_any;
  logic                take;
  logic                sample;
  logic [WORD_W-1:0]   sreg;
  logic [WORD_W-1:0]   words [N_REQ];
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    acc;
  logic [CNT_W-1:0]    acc_next;
  int                  arb_k;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*WORD_W +: WORD_W];
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    arb_k   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_k = (int'(last_ptr) + i) % N_REQ;
      if (!gnt_any && req[arb_k[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_k[ID_W-1:0];
      end
    end
  end

  always_comb begin
    next_state = IDLE;
    gnt        = '0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          gnt[gnt_idx] = 1'b1;
          take         = 1'b1;
          next_state   = CLEAR;
        end else begin
          next_state = IDLE;
        end
      end
      CLEAR: next_state = SHIFT;
      SHIFT: next_state = (cnt == CNT_W'(WORD_W - 1)) ? DRAIN : SHIFT;
      DRAIN: next_state = (cnt == CNT_W'(1)) ? DONE : DRAIN;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == CLEAR) || (state == SHIFT) || (state == DRAIN) || (state == DONE);

  // det_z lags det_w by two cycles, so SHIFT cycles 0/1 still show the cleared
  // history; the last two word bits only appear during DRAIN.
  assign sample   = ((state == SHIFT) && (cnt >= CNT_W'(2))) || (state == DRAIN);
  assign acc_next = (sample && det_z && (acc != CNT_W'(WORD_W))) ? acc + 1'b1 : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_ptr  <= ID_W'(N_REQ - 1);
      cur_id    <= '0;
      sreg      <= '0;
      cnt       <= '0;
      acc       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
      hit       <= 1'b0;
      det_w     <= 1'b0;
      det_clr   <= 1'b1;
    end else begin
      state   <= next_state;
      done    <= (next_state == DONE);
      // Driven from next_state so the detector pins are clean flop outputs
      // that line up with the state they belong to.
      det_clr <= (next_state == IDLE) || (next_state == CLEAR) || (next_state == DONE);

      if (take) begin
        sreg     <= words[gnt_idx];
        cur_id   <= gnt_idx;
        last_ptr <= gnt_idx;
      end else if (next_state == SHIFT) begin
        sreg <= sreg >> 1;
      end

      det_w <= (next_state == SHIFT) ? sreg[0] : 1'b0;

      if (state != next_state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == CLEAR) begin
        acc <= '0;
      end else begin
        acc <= acc_next;
      end

      // Fold in the final DRAIN sample as the result is published.
      if ((state == DRAIN) && (next_state == DONE)) begin
        hit_count <= acc_next;
        hit       <= (acc_next != '0);
        done_id   <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler with a behavioural run detector attached:
// directed words with hand-computed hit counts, round-robin order, and
// reset in the middle of a word.
module tb_seq_det_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [4:0]  hit_count;
  logic        hit;
  logic        det_clr;
  logic        det_w;
  logic        det_z = 1'b0;
  logic [3:0]  hist = 4'b0101;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_det_scheduler #(.N_REQ(4), .WORD_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .hit_count(hit_count), .hit(hit), .det_clr(det_clr), .det_w(det_w),
    .det_z(det_z)
  );

  // External detector: reset loads history 0101 (newest bit 1); z is the
  // registered 4-equal test of the history, i.e. two cycles after det_w.
  always @(posedge clk) begin
    if (det_clr) begin
      hist  <= 4'b0101;
      det_z <= 1'b0;
    end else begin
      hist  <= {hist[2:0], det_w};
      det_z <= (hist == 4'h0) || (hist == 4'hF);
    end
  end

  // Stimulus helper: presents one request, waits for its grant and its done.
  // lat = cycles from gnt to done (-1 if no done), extra = gnt pulses seen meanwhile.
  task automatic run_one(input logic [3:0] r, input int idx, input logic [15:0] w,
                         output logic [3:0] g, output int lat, output int extra);
    @(posedge clk); #1;
    req_data = '0;
    req_data[idx*16 +: 16] = w;
    req = r;
    g = '0; lat = -1; extra = 0;
    for (int n = 0; n < 40 && g == 4'd0; n++) begin
      @(negedge clk);
      if (gnt != 4'd0) g = gnt;
    end
    @(posedge clk); #1;
    req = '0;
    if (g != 4'd0) begin
      for (int n = 1; n <= 40 && lat < 0; n++) begin
        @(negedge clk);
        if (gnt != 4'd0) extra++;
        if (done) lat = n;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; req_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'd0)       begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (done_id !== 2'd0)   begin errors++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
    checks++; if (hit_count !== 5'd0) begin errors++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
    checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (det_w !== 1'b0)     begin errors++; $display("FAIL reset_det_w: got %b expected 0", det_w); end
    checks++; if (det_clr !== 1'b1)   begin errors++; $display("FAIL reset_det_clr: got %b expected 1", det_clr); end
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || gnt !== 4'd0 || det_clr !== 1'b1) begin
        errors++;
        $display("FAIL idle_no_req: busy=%b gnt=%b det_clr=%b expected 0/0000/1", busy, gnt, det_clr);
      end
    end
  endtask

  task automatic test_zeros;
    logic [3:0] g; int lat; int extra;
    run_one(4'b0001, 0, 16'h0000, g, lat, extra);
    checks++; if (g !== 4'b0001)      begin errors++; $display("FAIL zeros_gnt: got %b expected 0001", g); end
    checks++; if (lat != 20)          begin errors++; $display("FAIL zeros_latency: got %0d expected 20", lat); end
    checks++; if (extra != 0)         begin errors++; $display("FAIL zeros_single_gnt: got %0d extra pulses expected 0", extra); end
    checks++; if (hit_count !== 5'd13) begin errors++; $display("FAIL zeros_hit_count: got %0d expected 13", hit_count); end
    checks++; if (hit !== 1'b1)       begin errors++; $display("FAIL zeros_hit: got %b expected 1", hit); end
    checks++; if (done_id !== 2'd0)   begin errors++; $display("FAIL zeros_done_id: got %0d expected 0", done_id); end
    checks++; if (busy !== 1'b1 || det_clr !== 1'b1) begin
      errors++; $display("FAIL zeros_done_cycle: busy=%b det_clr=%b expected 1/1", busy, det_clr);
    end
  endtask

  task automatic test_ones;
    logic [3:0] g; int lat; int extra;
    run_one(4'b0010, 1, 16'hFFFF, g, lat, extra);
    checks++; if (g !== 4'b0010)       begin errors++; $display("FAIL ones_gnt: got %b expected 0010", g); end
    checks++; if (lat != 20)           begin errors++; $display("FAIL ones_latency: got %0d expected 20", lat); end
    checks++; if (hit_count !== 5'd14) begin errors++; $display("FAIL ones_hit_count: got %0d expected 14", hit_count); end
    checks++; if (done_id !== 2'd1)    begin errors++; $display("FAIL ones_done_id: got %0d expected 1", done_id); end
  endtask

  task automatic test_patterns;
    logic [3:0] g; int lat; int extra;
    run_one(4'b0100, 2, 16'hAAAA, g, lat, extra);
    checks++; if (lat != 20)          begin errors++; $display("FAIL alt_latency: got %0d expected 20", lat); end
    checks++; if (hit_count !== 5'd0) begin errors++; $display("FAIL alt_hit_count: got %0d expected 0", hit_count); end
    checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL alt_hit: got %b expected 0", hit); end
    checks++; if (done_id !== 2'd2)   begin errors++; $display("FAIL alt_done_id: got %0d expected 2", done_id); end
    run_one(4'b1000, 3, 16'h00F0, g, lat, extra);
    checks++; if (lat != 20)          begin errors++; $display("FAIL f0_latency: got %0d expected 20", lat); end
    checks++; if (hit_count !== 5'd7) begin errors++; $display("FAIL f0_hit_count: got %0d expected 7", hit_count); end
    checks++; if (done_id !== 2'd3)   begin errors++; $display("FAIL f0_done_id: got %0d expected 3", done_id); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || hit_count !== 5'd7) begin
      errors++; $display("FAIL f0_hold: done=%b hit_count=%0d expected 0/7", done, hit_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_g [5];
    logic [3:0] gv [5];
    int gc [5];
    int ng;
    logic seen_done;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin gv[i] = '0; gc[i] = 0; end
    ng = 0;
    @(posedge clk); #1;
    req_data = '0;
    req = 4'b1111;
    for (int n = 0; n < 200 && ng < 5; n++) begin
      @(negedge clk);
      if (gnt != 4'd0) begin
        checks++;
        if (!$onehot(gnt)) begin errors++; $display("FAIL rr_onehot: got %b expected one bit", gnt); end
        gv[ng] = gnt;
        gc[ng] = n;
        ng++;
        if (ng == 5) begin @(posedge clk); #1 req = '0; end
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gv[i] !== exp_g[i]) begin errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, gv[i], exp_g[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (gc[i] - gc[i-1] != 21) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 21", i, gc[i] - gc[i-1]); end
    end
    seen_done = 1'b0;
    for (int n = 0; n < 40 && !seen_done; n++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL rr_last_done: got none expected done"); end
  endtask

  task automatic test_reset_mid_word;
    logic [3:0] g; int lat; int extra;
    logic got;
    logic done_seen;
    @(posedge clk); #1;
    req_data = '0;
    req = 4'b0100;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (gnt != 4'd0) got = 1'b1;
    end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_gnt: got %b expected 0100", gnt); end
    @(posedge clk); #1 req = '0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (det_clr !== 1'b1 || busy !== 1'b0 || det_w !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: det_clr=%b busy=%b det_w=%b expected 1/0/0", det_clr, busy, det_w);
    end
    checks++; if (hit_count !== 5'd0 || done_id !== 2'd0) begin
      errors++; $display("FAIL abort_result_cleared: hit_count=%0d done_id=%0d expected 0/0", hit_count, done_id);
    end
    done_seen = done;
    repeat (3) begin @(negedge clk); if (done) done_seen = 1'b1; end
    @(posedge clk); #1 reset = 1'b0;
    repeat (25) begin @(negedge clk); if (done) done_seen = 1'b1; end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done expected none"); end
    run_one(4'b1111, 0, 16'h000F, g, lat, extra);
    checks++; if (g !== 4'b0001)       begin errors++; $display("FAIL abort_ptr_reset: got %b expected 0001", g); end
    checks++; if (lat != 20)           begin errors++; $display("FAIL abort_latency: got %0d expected 20", lat); end
    checks++; if (hit_count !== 5'd11) begin errors++; $display("FAIL abort_hit_count: got %0d expected 11", hit_count); end
    checks++; if (done_id !== 2'd0)    begin errors++; $display("FAIL abort_done_id: got %0d expected 0", done_id); end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_patterns();
    test_back_to_back();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
